// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Arbitrates between NUM_MST cache-side masters and hands one cache-line
// transaction at a time to the AXI interface controller. The winner's
// direction, address and write line are latched. A one-cycle request strobe
// is issued to the interface. The block then waits for the matching
// completion pulse and returns a one-cycle ready pulse, plus the read line
// for reads, to the owning master. A master may cancel its own outstanding
// transaction. The bus side still completes, but the response is dropped.
// An optional completion timeout ends the wait early and reports an error.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mst_req_i       per-master request level (held until ready)
//   mst_rw_i        per-master direction, 1 = read, 0 = write
//   mst_addr_i      packed addresses, master k at [k*ADDR_W +: ADDR_W]
//   mst_wdata_i     packed write lines, master k at [k*LINE_W +: LINE_W]
//   mst_cancel_i    per-master cancel (drops the owner's response)
//   mst_ready_o     one-hot, one-cycle completion pulse
//   mst_rdata_o     last read line, valid with the ready pulse
//   mst_err_o       timeout error, valid with the ready pulse
//   bc_valid_req_o  one-cycle request strobe to the interface
//   bc_rw_o         latched direction to the interface
//   bc_addr_o       latched address to the interface
//   bc_data_o       latched write line to the interface (0 for reads)
//   axi_data_i      read line from the interface
//   axi_rd_over_i   read-complete pulse
//   axi_wr_over_i   write-complete pulse
//   busy_o          high whenever a transaction is in progress
//
// Handshake: a master presents mst_req_i with stable rw/addr/wdata and
// keeps it up until it sees its mst_ready_o bit. On the interface side,
// bc_valid_req_o is a single-cycle strobe. Completion is a single-cycle
// axi_*_over_i pulse of the matching direction.
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int NUM_MST   = 3,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int PRIO_MODE = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MST-1:0]        mst_req_i,
    input  logic [NUM_MST-1:0]        mst_rw_i,
    input  logic [NUM_MST*ADDR_W-1:0] mst_addr_i,
    input  logic [NUM_MST*LINE_W-1:0] mst_wdata_i,
    input  logic [NUM_MST-1:0]        mst_cancel_i,
    output logic [NUM_MST-1:0]        mst_ready_o,
    output logic [LINE_W-1:0]         mst_rdata_o,
    output logic                      mst_err_o,
    output logic                      bc_valid_req_o,
    output logic                      bc_rw_o,
    output logic [ADDR_W-1:0]         bc_addr_o,
    output logic [LINE_W-1:0]         bc_data_o,
    input  logic [LINE_W-1:0]         axi_data_i,
    input  logic                      axi_rd_over_i,
    input  logic                      axi_wr_over_i,
    output logic                      busy_o
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic [IDX_W:0]   NUM_L    = (IDX_W + 1)'(NUM_MST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               drop_q, drop_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  data_q, data_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;

    logic [NUM_MST-1:0] elig;
    logic [IDX_W-1:0]   base;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   win;
    logic               any_elig;
    logic               sel_rw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LINE_W-1:0]  sel_data;
    logic               bus_done;
    logic               own_cancel;

    // Winner search. Candidates are visited from the last position in
    // search order down to the first, so the first eligible one in search
    // order is the last assignment to stick.
    always_comb begin
        elig     = mst_req_i & ~mst_cancel_i;
        base     = (PRIO_MODE != 0) ? ptr_q : '0;
        cand     = '0;
        win      = '0;
        any_elig = 1'b0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            cand = {1'b0, base} + (IDX_W + 1)'(i);
            if (cand >= NUM_L) begin
                cand = cand - NUM_L;
            end
            if (elig[cand[IDX_W-1:0]]) begin
                win      = cand[IDX_W-1:0];
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rw   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (win == IDX_W'(k)) begin
                sel_rw   = mst_rw_i[k];
                sel_addr = mst_addr_i[k*ADDR_W +: ADDR_W];
                sel_data = mst_wdata_i[k*LINE_W +: LINE_W];
            end
        end
    end

    // Only the completion pulse matching the latched direction counts.
    assign bus_done   = (rw_q & axi_rd_over_i) | (~rw_q & axi_wr_over_i);
    assign own_cancel = mst_cancel_i[owner_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    state_d = S_ISSUE;
                    owner_d = win;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    data_d  = sel_rw ? '0 : sel_data;
                    drop_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                if (own_cancel) drop_d = 1'b1;
            end
            S_WAIT: begin
                if (own_cancel) drop_d = 1'b1;
                // Saturating counter: never wraps back into range.
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                // Completion is checked first so it beats a same-cycle timeout.
                if (bus_done) begin
                    state_d = S_DONE;
                    if (rw_q) rdata_d = axi_data_i;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    // This is the TIMEOUT-th wait cycle.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        mst_ready_o = '0;
        if (state_q == S_DONE && !drop_q) mst_ready_o[owner_q] = 1'b1;
    end

    assign mst_err_o      = (state_q == S_DONE) & ~drop_q & err_q;
    assign mst_rdata_o    = rdata_q;
    assign bc_valid_req_o = (state_q == S_ISSUE);
    assign bc_rw_o        = rw_q;
    assign bc_addr_o      = addr_q;
    assign bc_data_o      = data_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-master bus arbiter and request sequencer between the cache-side masters (Dcache, Icache, future DMA/PTW) and the AXI interface controller.
- Grants one outstanding cache-line transaction at a time, with fixed or round-robin priority.
- Issues a single-cycle request to the interface, waits for read or write completion, and returns data or a ready pulse to the owner.
- Beyond the single-owner controller, it adds per-master cancel (response drop), a completion timeout with error reporting, and a configurable master count and width.

Parameters:
- NUM_MST, 3, number of masters; index 0 has highest fixed priority (Dcache at 0).
- ADDR_W, 32, address width.
- LINE_W, 128, line data width.
- PRIO_MODE, 1, 0 = fixed priority, 1 = round-robin.
- TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mst_req_i  in  NUM_MST  per-master request level, held until that master's ready pulse
- mst_rw_i  in  NUM_MST  per-master direction, 1 = read, 0 = write
- mst_addr_i  in  NUM_MST*ADDR_W  packed addresses; master k uses bits [k*ADDR_W +: ADDR_W]
- mst_wdata_i  in  NUM_MST*LINE_W  packed write lines
- mst_cancel_i  in  NUM_MST  per-master cancel (e.g. Icache jump flush)
- mst_ready_o  out  NUM_MST  one-hot, one-cycle completion pulse
- mst_rdata_o  out  LINE_W  read line, valid while the owner's ready bit is high
- mst_err_o  out  1  timeout error, valid with the ready pulse
- bc_valid_req_o  out  1  one-cycle request strobe to the interface
- bc_rw_o  out  1  direction to the interface
- bc_addr_o  out  ADDR_W  address to the interface
- bc_data_o  out  LINE_W  write data to the interface
- axi_data_i  in  LINE_W  read data from the interface
- axi_rd_over_i  in  1  read-complete pulse
- axi_wr_over_i  in  1  write-complete pulse
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, rst = 1):
  - State goes to IDLE.
  - All outputs are 0.
  - Round-robin pointer, owner, drop flag and timeout counter are 0.
  - A reset mid-transaction abandons it with no ready pulse.
  - Completion pulses arriving in IDLE are ignored.
- Eligibility: master k is eligible when mst_req_i[k] = 1 and mst_cancel_i[k] = 0.
- State machine (all transitions registered):
  - IDLE:
    - If any master is eligible, select a winner, latch its rw, addr and wdata (wdata latched as 0 for reads), set owner, clear drop, clear the counter, and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - bc_valid_req_o = 1 for exactly this one cycle; bc_rw_o, bc_addr_o and bc_data_o take the latched values.
    - These values hold stable until the next ISSUE.
    - Go to WAIT.
  - WAIT:
    - Counter increments every cycle.
    - Completion condition: (bus_rw & axi_rd_over_i) | (~bus_rw & axi_wr_over_i). The mismatched-direction completion pulse is ignored.
    - On completion: latch axi_data_i into mst_rdata_o for reads and go to DONE.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT without completion: set the error flag and go to DONE.
  - DONE:
    - If the drop flag is clear, mst_ready_o[owner] = 1 for one cycle, with mst_err_o = error flag.
    - If the drop flag is set, no ready pulse and no error are produced.
    - No arbitration takes place in DONE, which lets the master drop its request.
    - Go to IDLE; mst_ready_o and mst_err_o return to 0.
- Priority:
  - Fixed mode: lowest eligible index wins.
  - Round-robin mode: search starts at pointer and proceeds upward with wrap-around; the first eligible master wins.
  - On leaving DONE, pointer = (owner + 1) mod NUM_MST, including after a dropped or timed-out transaction.
- Cancel:
  - mst_cancel_i[owner] = 1 in any cycle of ISSUE or WAIT sets the drop flag.
  - The bus transaction still completes; only the response is suppressed.
  - Cancel on a non-owner has no effect.
- Latency: request sampled in IDLE at cycle t gives bc_valid_req_o at t+1. Completion at cycle c gives mst_ready_o at c+1. Minimum turnaround is 4 cycles.
- Simultaneous completion and timeout in the same cycle: completion wins, err = 0.
- Simultaneous axi_rd_over_i and axi_wr_over_i: only the one matching bus_rw is honoured.
- mst_rdata_o is 0 after reset and otherwise holds its last read value.
- Timeout counter width is clog2(TIMEOUT+1) and it saturates (never wraps).

Test Plan:
- Single read: master 1 reads addr 0x0000_1000; axi_rd_over_i 5 cycles after the strobe with data 0xA5…A5 -> one bc_valid_req_o with rw = 1, addr 0x1000; mst_ready_o = 3'b010 one cycle later with rdata 0xA5…A5 and err = 0.
- Write: master 0 writes 0x2000 with data 0x1234; wr_over arrives -> bc_rw_o = 0, bc_data_o = 0x1234; mst_ready_o = 3'b001. A spurious rd_over in WAIT is ignored.
- Arbitration: all three masters hold req continuously.
  - PRIO_MODE = 1: grant order 0, 1, 2, 0.
  - PRIO_MODE = 0: grant order 0, 0, 0 while master 0 holds its request.
- Cancel: master 2 is granted and mst_cancel_i[2] pulses during WAIT -> the transaction still completes on the bus, no mst_ready_o bit is set, busy_o drops, and the next grant proceeds normally.
- Timeout: TIMEOUT = 8 and no completion -> mst_ready_o[owner] = 1 with mst_err_o = 1 after 8 WAIT cycles. A completion arriving in the same cycle as the limit gives err = 0.
- Reset mid-WAIT: rst = 1 for one cycle -> all outputs 0, IDLE. A later axi_rd_over_i produces no ready pulse.
